// File: rtl/i2c_bit_sequencer_pkg.sv
// Shared types and constants for the I2C slave bit sequencer.
//   seq_state_t     : sequencer FSM states
//   DefaultDataBits : data bits per byte before the ACK slot
//   BitCountWidth   : width of the data bit counter
package i2c_pkg;

  localparam int unsigned DefaultDataBits = 8;
  localparam int unsigned BitCountWidth   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StAckWaitFall,
    StAckWaitRise,
    StAckWaitEnd
  } seq_state_t;

endpackage

// File: rtl/i2c_bit_sequencer_if.sv
// Bus bundle between the SCL/SDA edge detectors, the bit sequencer and the slave controller.
//   scl_rise, scl_fall       : one-cycle SCL edge pulses
//   start_found, stop_found  : one-cycle bus condition pulses
//   tx_enable                : slave transmitting, selects TX shift timing
//   shift_strobe             : shift-register advance pulse
//   byte_received, ack_prep,
//   check_ack, ack_done      : phase pulses for the slave controller
//   bit_count                : data bits counted in the current byte
//   busy                     : sequencer not idle
// The slave modport is the sequencer; the master modport drives events and observes phases.
interface i2c_bit_sequencer_if;

  logic       scl_rise;
  logic       scl_fall;
  logic       start_found;
  logic       stop_found;
  logic       tx_enable;
  logic       shift_strobe;
  logic       byte_received;
  logic       ack_prep;
  logic       check_ack;
  logic       ack_done;
  logic [3:0] bit_count;
  logic       busy;

  modport slave (
    input  scl_rise,
    input  scl_fall,
    input  start_found,
    input  stop_found,
    input  tx_enable,
    output shift_strobe,
    output byte_received,
    output ack_prep,
    output check_ack,
    output ack_done,
    output bit_count,
    output busy
  );

  modport master (
    output scl_rise,
    output scl_fall,
    output start_found,
    output stop_found,
    output tx_enable,
    input  shift_strobe,
    input  byte_received,
    input  ack_prep,
    input  check_ack,
    input  ack_done,
    input  bit_count,
    input  busy
  );

endinterface

// File: rtl/i2c_bit_sequencer_bit_counter.sv
// Saturating up-counter for data bits.
//   clk, n_rst : clock, asynchronous active-low reset
//   clear      : synchronous clear, wins over count_en
//   count_en   : advance by one unless already at rollover
//   rollover   : saturation value
//   count      : registered count
module bit_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_en,
  input  logic [Width-1:0] rollover,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && (count_q != rollover)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/i2c_bit_sequencer.sv
// I2C slave bit/byte timing sequencer. Counts data bits on SCL rises, walks the ACK slot
// and emits registered one-cycle phase strobes plus the RX/TX shift strobe.
//   clk, n_rst : clock, asynchronous active-low reset
//   bus        : slave modport of i2c_bit_sequencer_if (events in, strobes/count/busy out)
// Priority: stop_found > start_found > SCL edges. Coincident rise and fall are ignored.
module i2c_bit_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned DATA_BITS = DefaultDataBits
) (
  input logic                clk,
  input logic                n_rst,
  i2c_bit_sequencer_if.slave bus
);

  localparam logic [BitCountWidth-1:0] LastBit = BitCountWidth'(DATA_BITS);
  localparam logic [BitCountWidth-1:0] PenultBit = BitCountWidth'(DATA_BITS - 1);

  seq_state_t state_q, state_d;

  logic shift_q, shift_d;
  logic byte_q, byte_d;
  logic prep_q, prep_d;
  logic check_q, check_d;
  logic done_q, done_d;

  logic                     count_clear;
  logic                     count_en;
  logic [BitCountWidth-1:0] bit_count;

  // A simultaneous rise and fall is treated as no edge at all.
  logic rise_only, fall_only;
  assign rise_only = bus.scl_rise & ~bus.scl_fall;
  assign fall_only = bus.scl_fall & ~bus.scl_rise;

  always_comb begin
    state_d     = state_q;
    shift_d     = 1'b0;
    byte_d      = 1'b0;
    prep_d      = 1'b0;
    check_d     = 1'b0;
    done_d      = 1'b0;
    count_clear = 1'b0;
    count_en    = 1'b0;

    if (bus.stop_found) begin
      state_d     = StIdle;
      count_clear = 1'b1;
    end else if (bus.start_found) begin
      state_d     = StData;
      count_clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StData: begin
          if (rise_only) begin
            count_en = 1'b1;
            shift_d  = ~bus.tx_enable;
            if (bit_count == PenultBit) begin
              byte_d  = 1'b1;
              state_d = StAckWaitFall;
            end
          end else if (fall_only && bus.tx_enable) begin
            // The top TX bit is preloaded, so only falls after bits 1..N-1 shift.
            shift_d = (bit_count >= BitCountWidth'(1)) && (bit_count <= PenultBit);
          end
        end
        StAckWaitFall: begin
          if (fall_only) begin
            prep_d  = 1'b1;
            state_d = StAckWaitRise;
          end
        end
        StAckWaitRise: begin
          if (rise_only) begin
            check_d = 1'b1;
            state_d = StAckWaitEnd;
          end
        end
        StAckWaitEnd: begin
          if (fall_only) begin
            done_d      = 1'b1;
            count_clear = 1'b1;
            state_d     = StData;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      shift_q <= 1'b0;
      byte_q  <= 1'b0;
      prep_q  <= 1'b0;
      check_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      prep_q  <= prep_d;
      check_q <= check_d;
      done_q  <= done_d;
    end
  end

  bit_counter #(
    .Width(BitCountWidth)
  ) u_bit_counter (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (count_clear),
    .count_en(count_en),
    .rollover(LastBit),
    .count   (bit_count)
  );

  assign bus.shift_strobe  = shift_q;
  assign bus.byte_received = byte_q;
  assign bus.ack_prep      = prep_q;
  assign bus.check_ack     = check_q;
  assign bus.ack_done      = done_q;
  assign bus.bit_count     = bit_count;
  assign bus.busy          = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// Scoreboard bench for i2c_bit_sequencer: stimulus pushes the expected strobe set, capture
// cycle and bit_count; a negedge monitor pops and compares whenever any strobe is high.
module tb_i2c_bit_sequencer;

  localparam logic [4:0] MShift = 5'b10000;
  localparam logic [4:0] MByte  = 5'b01000;
  localparam logic [4:0] MPrep  = 5'b00100;
  localparam logic [4:0] MCheck = 5'b00010;
  localparam logic [4:0] MDone  = 5'b00001;
  localparam logic [4:0] MNone  = 5'b00000;

  typedef struct {
    int         cyc;
    logic [4:0] mask;
    logic [3:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  i2c_bit_sequencer_if bus ();

  i2c_bit_sequencer #(
    .DATA_BITS(8)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle carrying a strobe must match the next expected entry.
  always @(negedge clk) begin : mon
    logic [4:0] mask;
    exp_t       e;
    mask = {bus.shift_strobe, bus.byte_received, bus.ack_prep, bus.check_ack, bus.ack_done};
    if (n_rst && mask != 5'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got mask %b expected none (cycle %0d)", mask, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_mask", {27'b0, mask}, {27'b0, e.mask});
        chk("strobe_bit_count", {28'b0, bus.bit_count}, {28'b0, e.cnt});
      end
    end
  end

  // Called at posedge+1: drives one cycle of events; the DUT captures them on the next edge.
  task automatic ev(input logic r, input logic f, input logic s, input logic p,
                    input logic [4:0] mask, input logic [3:0] cnt);
    bus.scl_rise    = r;
    bus.scl_fall    = f;
    bus.start_found = s;
    bus.stop_found  = p;
    if (mask != 5'b0) exp_q.push_back('{cyc + 1, mask, cnt});
    @(posedge clk);
    #1;
    bus.scl_rise    = 1'b0;
    bus.scl_fall    = 1'b0;
    bus.start_found = 1'b0;
    bus.stop_found  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL rise/fall pair, 10 cycles per bit.
  task automatic bit_pair(input logic [4:0] rm, input logic [3:0] rc,
                          input logic [4:0] fm, input logic [3:0] fc);
    ev(1'b1, 1'b0, 1'b0, 1'b0, rm, rc);
    idle(4);
    ev(1'b0, 1'b1, 1'b0, 1'b0, fm, fc);
    idle(4);
  endtask

  task automatic start_ev();
    ev(1'b0, 1'b0, 1'b1, 1'b0, MNone, 4'd0);
    idle(2);
  endtask

  task automatic stop_ev();
    ev(1'b0, 1'b0, 1'b0, 1'b1, MNone, 4'd0);
    idle(2);
  endtask

  initial begin
    bus.scl_rise    = 1'b0;
    bus.scl_fall    = 1'b0;
    bus.start_found = 1'b0;
    bus.stop_found  = 1'b0;
    bus.tx_enable   = 1'b0;

    // Reset state
    #2;
    chk("reset_bit_count", {28'b0, bus.bit_count}, 0);
    chk("reset_busy", {31'b0, bus.busy}, 0);
    chk("reset_strobes", {27'b0, bus.shift_strobe, bus.byte_received, bus.ack_prep,
                          bus.check_ack, bus.ack_done}, 0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    idle(2);

    // RX byte: shift on every rise, byte on the 8th, then the ACK slot
    start_ev();
    chk("rx_busy_after_start", {31'b0, bus.busy}, 1);
    for (int i = 1; i <= 8; i++) begin
      if (i < 8) bit_pair(MShift, 4'(i), MNone, 4'd0);
      else       bit_pair(MShift | MByte, 4'd8, MPrep, 4'd8);
    end
    bit_pair(MCheck, 4'd8, MDone, 4'd0);
    chk("rx_count_after_ack", {28'b0, bus.bit_count}, 0);
    chk("rx_busy_after_ack", {31'b0, bus.busy}, 1);

    // Coincident rise and fall in DATA are ignored
    ev(1'b1, 1'b0, 1'b0, 1'b0, MShift, 4'd1);
    idle(4);
    ev(1'b1, 1'b1, 1'b0, 1'b0, MNone, 4'd0);
    idle(4);
    chk("both_edges_count", {28'b0, bus.bit_count}, 1);
    stop_ev();

    // TX byte: shift on falls after bits 1..7 only
    bus.tx_enable = 1'b1;
    start_ev();
    for (int i = 1; i <= 8; i++) begin
      if (i < 8) bit_pair(MNone, 4'd0, MShift, 4'(i));
      else       bit_pair(MByte, 4'd8, MPrep, 4'd8);
    end
    bit_pair(MCheck, 4'd8, MDone, 4'd0);
    bus.tx_enable = 1'b0;
    stop_ev();

    // STOP after the 5th rise
    start_ev();
    for (int i = 1; i <= 5; i++) begin
      ev(1'b1, 1'b0, 1'b0, 1'b0, MShift, 4'(i));
      idle(4);
      if (i < 5) begin
        ev(1'b0, 1'b1, 1'b0, 1'b0, MNone, 4'd0);
        idle(4);
      end
    end
    ev(1'b0, 1'b0, 1'b0, 1'b1, MNone, 4'd0);
    chk("stop_busy", {31'b0, bus.busy}, 0);
    chk("stop_count", {28'b0, bus.bit_count}, 0);
    idle(2);
    for (int i = 0; i < 4; i++) bit_pair(MNone, 4'd0, MNone, 4'd0);
    chk("stop_count_after_edges", {28'b0, bus.bit_count}, 0);

    // Repeated START in ACK_WAIT_RISE
    start_ev();
    for (int i = 1; i <= 8; i++) begin
      if (i < 8) bit_pair(MShift, 4'(i), MNone, 4'd0);
      else       bit_pair(MShift | MByte, 4'd8, MPrep, 4'd8);
    end
    ev(1'b0, 1'b0, 1'b1, 1'b0, MNone, 4'd0);
    chk("rstart_count", {28'b0, bus.bit_count}, 0);
    chk("rstart_busy", {31'b0, bus.busy}, 1);
    idle(2);
    for (int i = 1; i <= 8; i++) begin
      if (i < 8) bit_pair(MShift, 4'(i), MNone, 4'd0);
      else       bit_pair(MShift | MByte, 4'd8, MPrep, 4'd8);
    end
    stop_ev();

    // Asynchronous reset at bit_count 6
    start_ev();
    for (int i = 1; i <= 6; i++) bit_pair(MShift, 4'(i), MNone, 4'd0);
    chk("pre_reset_count", {28'b0, bus.bit_count}, 6);
    #2 n_rst = 1'b0;
    #1;
    chk("async_reset_count", {28'b0, bus.bit_count}, 0);
    chk("async_reset_busy", {31'b0, bus.busy}, 0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    idle(1);
    ev(1'b1, 1'b0, 1'b0, 1'b0, MNone, 4'd0);
    idle(2);
    chk("post_reset_rise_count", {28'b0, bus.bit_count}, 0);
    chk("post_reset_rise_busy", {31'b0, bus.busy}, 0);
    start_ev();
    chk("post_reset_start_busy", {31'b0, bus.busy}, 1);
    bit_pair(MShift, 4'd1, MNone, 4'd0);
    stop_ev();

    idle(5);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_bit_sequencer.md
# i2c_bit_sequencer

Bit/byte timing sequencer for the I2C slave. It consumes single-cycle SCL edge pulses and bus start/stop events, counts data bits, and generates the phase strobes the slave controller sequences on: `byte_received`, `ack_prep`, `check_ack` and `ack_done`. It also generates the shift strobe for the RX/TX shift registers. It sits between the SCL/SDA edge detectors and the slave controller FSM.

## Interface
- DATA_BITS, 8, data bits per byte before the ACK slot (legal 2..15)
- clk  in  1  system clock
- n_rst  in  1  reset n_rst, asynchronous, active-low; clock clk
- scl_rise  in  1  one-cycle pulse, SCL rising edge detected
- scl_fall  in  1  one-cycle pulse, SCL falling edge detected
- start_found  in  1  one-cycle pulse, START or repeated START
- stop_found  in  1  one-cycle pulse, STOP
- tx_enable  in  1  slave is transmitting; selects the TX shift timing
- shift_strobe  out  1  shift-register advance pulse
- byte_received  out  1  pulse, DATA_BITS bits sampled
- ack_prep  out  1  pulse, SCL fell into the ACK slot
- check_ack  out  1  pulse, SCL rose in the ACK slot (sample SDA)
- ack_done  out  1  pulse, SCL fell ending the ACK slot
- bit_count  out  4  data bits counted in the current byte
- busy  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE: wait for a bus event.
  - DATA: count data bits.
  - ACK_WAIT_FALL: byte complete; wait for SCL to fall into the ACK slot.
  - ACK_WAIT_RISE: wait for the ACK sample edge.
  - ACK_WAIT_END: wait for SCL to fall at the end of the ACK slot.
- IDLE -> DATA on start_found; bit_count cleared.
- DATA:
  - each scl_rise increments bit_count.
  - On the rise that makes bit_count == DATA_BITS, pulse byte_received and go to ACK_WAIT_FALL.
- ACK_WAIT_FALL -> ACK_WAIT_RISE on scl_fall; pulse ack_prep.
- ACK_WAIT_RISE -> ACK_WAIT_END on scl_rise; pulse check_ack.
- ACK_WAIT_END -> DATA on scl_fall; pulse ack_done and clear bit_count to 0.
- shift_strobe:
  - tx_enable=0: shift_strobe = scl_rise in DATA.
  - tx_enable=1: shift_strobe = scl_fall in DATA when 1 <= bit_count <= DATA_BITS-1.
  - Bit DATA_BITS-1 is placed by load_data before the first rise, so no fall after the final bit produces a shift.
  - shift_strobe is never asserted outside DATA.
- Event priority, highest first:
  1. stop_found: go to IDLE, clear bit_count, no phase pulse.
  2. start_found: go to DATA and clear bit_count from any state, including mid-byte or mid-ACK (repeated START).
  3. SCL edges.
- scl_rise and scl_fall in the same cycle: both ignored, no state change.
- bit_count saturates at DATA_BITS and never wraps.

## Timing
- All outputs are registered and appear exactly 1 clk after the causing input pulse.
- Every pulse output is exactly 1 cycle wide.
- At most one of byte_received, ack_prep, check_ack, ack_done is high in any cycle.
- Reset values: state IDLE, bit_count 0, busy 0, all pulse outputs 0.
- Reset mid-byte or mid-ACK: the same values take effect immediately (asynchronous).
- Inputs are synchronous to clk, already synchronized and edge-detected upstream.
- Minimum spacing between edge pulses is 2 cycles; denser input is undefined.

## Structure
- Package i2c_pkg holds:
  - seq_state_t enum (IDLE, DATA, ACK_WAIT_FALL, ACK_WAIT_RISE, ACK_WAIT_END).
  - The DATA_BITS default constant.
- Sub-module bit_counter: clear, count-enable, rollover value, saturating output.
- The FSM and output registers stay in i2c_bit_sequencer.

## Test plan
- start_found, then 8 scl_rise/scl_fall pairs 10 cycles apart:
  - bit_count steps 1..8.
  - 8 shift_strobe pulses, each 1 cycle after a rise.
  - byte_received 1 cycle after the 8th rise.
  - ACK slot then yields ack_prep, check_ack, ack_done in order, each 1 cycle after its edge.
  - bit_count returns to 0 with ack_done.
- tx_enable=1, full byte:
  - exactly 7 shift_strobe pulses, on the falls after bits 1..7.
  - none on the fall into the ACK slot.
  - ack_prep on that fall.
- stop_found after the 5th rise: next cycle busy=0, bit_count=0; no byte_received on further SCL edges.
- start_found during ACK_WAIT_RISE:
  - bit_count=0 and state DATA.
  - no check_ack.
  - the next 8 rises give byte_received.
- n_rst low at bit_count=6: all outputs 0 immediately; after release, an scl_rise alone changes nothing until start_found.
- scl_rise and scl_fall asserted in the same cycle in DATA: bit_count unchanged, no shift_strobe.
